tx_scheduler: RTL and testbench
===============================

Name: tx_scheduler

Overview:
Round-robin scheduler that shares the serial transmitting path between two byte requesters. It frames each granted byte into a 10-bit character (start, 8 data bits, stop) and drives the transmitter's parallel load and enable. It watches the transmitter's character-sent flag, returns a one-cycle acknowledge to the owning requester, and aborts with an error if the character never completes. It sits between the command/data sources and the transmitter.

Parameters:
TIMEOUT, 4096, clocks allowed in SEND before abort; counter width is $clog2(TIMEOUT+1).
GAP_CYCLES, 16, idle clocks inserted between characters; used only with TX_GAP_EN.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req0  input  1  requester 0 wants to send; held high until ack0
data0  input  8  requester 0 byte; stable while req0 is high
req1  input  1  requester 1 wants to send; held high until ack1
data1  input  8  requester 1 byte; stable while req1 is high
char_sent  input  1  transmitter flag, high for at least one clock when the last bit is out
frame  output  10  character to transmitter parallel input
load_n  output  1  active-low parallel load strobe to transmitter
t_enable  output  1  transmitter enable
ack0  output  1  one-clock pulse: requester 0 character finished or aborted
ack1  output  1  one-clock pulse: requester 1 character finished or aborted
tx_err  output  1  one-clock pulse coincident with ackN when the character timed out
busy  output  1  high in every state except IDLE
grant_id  output  1  owner of the current or last character

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, frame=10'h3FF, load_n=1, t_enable=0, ack0=ack1=tx_err=0, busy=0, grant_id=1, timeout counter=0. grant_id=1 makes req0 win the first tie.
- Frame format: frame[0]=0 (start), frame[8:1]=data[7:0] (frame[1]=data[0]), frame[9]=1 (stop). Bit 0 is transmitted first.
- States: IDLE, LOAD, SEND, DONE (plus GAP with TX_GAP_EN).
- IDLE: if only reqN is high, grant N. If both are high, grant the requester not equal to grant_id. On grant, register grant_id and frame from the selected data, then go to LOAD. With no request, stay in IDLE.
- LOAD (1 clock): load_n=0, t_enable=0. Next state is SEND.
- SEND: t_enable=1 and load_n=1. The timeout counter increments each clock.
  - If char_sent=1, go to DONE (normal completion).
  - Else if counter reaches TIMEOUT-1, go to DONE with an abort flag set.
  - If char_sent and timeout occur on the same clock, char_sent wins: normal completion, no error.
- DONE (1 clock): t_enable=0. ack[grant_id]=1. tx_err=abort flag. The counter and abort flag clear. Next state is IDLE (or GAP).
- Latency: the grant decision is made in IDLE; load_n is low on the next clock; t_enable rises one clock later. ackN rises one clock after char_sent is sampled.
- A requester must drop reqN on the clock after ackN. A reqN still high in IDLE is treated as a new request.
- Requests and data changes are ignored outside IDLE; the frame stays frozen from LOAD through DONE.
- frame holds its last value after DONE.
- Reset asserted mid-character: immediate return to the reset values; no ack is issued.
- A char_sent pulse seen in IDLE, LOAD or DONE is ignored.

Optional Feature:
TX_GAP_EN.
- Defined: DONE goes to GAP. GAP holds t_enable=0 and load_n=1 and keeps busy=1 for GAP_CYCLES clocks, reusing the timeout counter, then goes to IDLE. Requests are not sampled during GAP.
- Undefined: no GAP state. DONE goes directly to IDLE, so back-to-back characters are separated only by the IDLE decision clock.

Test Plan:
- Reset with req0=1, data0=8'hA5 held -> all outputs at their reset values; after release, load_n=0 for exactly 1 clock, frame=10'b1_10100101_0 (10'h34A), grant_id=0, then t_enable=1.
- Single request, data1=8'h3C; assert char_sent 100 clocks into SEND -> ack1 is a one-clock pulse the clock after char_sent, tx_err=0, t_enable=0, and the scheduler returns to IDLE.
- req0 and req1 both held high for 4 characters -> grant order 0,1,0,1, with matching ack pulses and frames.
- char_sent never asserted -> after TIMEOUT=4096 SEND clocks, ack0=1 and tx_err=1 on the same clock, and t_enable drops.
- char_sent asserted on the same clock the timeout expires -> ack pulses with tx_err=0.
- Reset pulled low mid-SEND -> t_enable=0 and busy=0 asynchronously, with no ack. With TX_GAP_EN, a second character's load_n is low no earlier than GAP_CYCLES+2 clocks after the first ack.

Source files
------------

// File: rtl/tx_scheduler_if.sv
// Requester/transmitter-side bundle for tx_scheduler.
// The master modport is the sources + transmitter side; the slave modport is the scheduler.
interface tx_scheduler_if;
   logic       req0;
   logic [7:0] data0;
   logic       req1;
   logic [7:0] data1;
   logic       char_sent;
   logic [9:0] frame;
   logic       load_n;
   logic       t_enable;
   logic       ack0;
   logic       ack1;
   logic       tx_err;
   logic       busy;
   logic       grant_id;

   modport master (
      output req0, data0, req1, data1, char_sent,
      input  frame, load_n, t_enable, ack0, ack1, tx_err, busy, grant_id
   );

   modport slave (
      input  req0, data0, req1, data1, char_sent,
      output frame, load_n, t_enable, ack0, ack1, tx_err, busy, grant_id
   );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin two-requester scheduler framing bytes for a serial transmitter, with SEND timeout.
// Define TX_GAP_EN to insert GAP_CYCLES idle clocks after every character.
//
// state | meaning
// IDLE  | arbitrate requests, latch grant_id and frame
// LOAD  | one-clock parallel load strobe (load_n=0)
// SEND  | transmitter enabled, timeout counter running
// DONE  | one-clock ack to owner, tx_err if aborted
// GAP   | inter-character idle time (TX_GAP_EN only)
module tx_scheduler #(
   parameter int TIMEOUT    = 4096,
   parameter int GAP_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   tx_scheduler_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef TX_GAP_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DONE, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_abort;
   logic               r_grant_id;
   logic [9:0]         r_frame;
   logic               w_req_any;
   logic               w_sel;
   logic               w_timeout;

   assign w_req_any = bus.req0 | bus.req1;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   // On a tie the requester that did not own the last character wins.
   always_comb begin
      w_sel = 1'b0;
      if (bus.req0 && bus.req1)
         w_sel = ~r_grant_id;
      else
         w_sel = ~bus.req0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_req_any) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_SEND;
         S_SEND: if (bus.char_sent || w_timeout) w_state_nxt = S_DONE;
`ifdef TX_GAP_EN
         S_DONE: w_state_nxt = S_GAP;
         S_GAP:  if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
`else
         S_DONE: w_state_nxt = S_IDLE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame    <= 10'h3FF;
         r_grant_id <= 1'b1;
         r_cnt      <= '0;
         r_abort    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_grant_id <= w_sel;
                  r_frame    <= {1'b1, (w_sel ? bus.data1 : bus.data0), 1'b0};
               end
            end
            S_SEND: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // char_sent on the expiry clock still counts as a clean finish
               if (!bus.char_sent && w_timeout)
                  r_abort <= 1'b1;
            end
            S_DONE: begin
               r_cnt   <= '0;
               r_abort <= 1'b0;
            end
`ifdef TX_GAP_EN
            S_GAP: begin
               if (r_cnt == CNT_W'(GAP_CYCLES - 1))
                  r_cnt <= '0;
               else
                  r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.frame    = r_frame;
   assign bus.load_n   = (r_state != S_LOAD);
   assign bus.t_enable = (r_state == S_SEND);
   assign bus.ack0     = (r_state == S_DONE) && !r_grant_id;
   assign bus.ack1     = (r_state == S_DONE) &&  r_grant_id;
   assign bus.tx_err   = (r_state == S_DONE) && r_abort;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: reset values, framing, round-robin order, timeout and reset abort.
module tb_tx_scheduler;

   localparam int TIMEOUT    = 4096;
   localparam int GAP_CYCLES = 16;
`ifdef TX_GAP_EN
   localparam int EXP_GAP = GAP_CYCLES + 2;
`else
   localparam int EXP_GAP = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   w_clks;

   tx_scheduler_if sif ();

   tx_scheduler #(
      .TIMEOUT    (TIMEOUT),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sif.busy !== 1'b0 && k < 64) begin
         tick();
         k++;
      end
      check("return to idle", sif.busy, 0);
   endtask

   // send_clks = 0: never raise char_sent (timeout path);
   // otherwise char_sent is sampled on the send_clks-th SEND clock.
   task automatic run_char(input bit id, input logic [9:0] fr, input int send_clks,
                           input bit err, input bit drop, output int wait_clks);
      int w = 0;
      int k = 0;
      while (sif.load_n !== 1'b0 && w < 64) begin
         tick();
         w++;
      end
      wait_clks = w;
      check("load_n low", sif.load_n, 0);
      check("frame at load", sif.frame, fr);
      check("grant_id", sif.grant_id, id);
      check("t_enable at load", sif.t_enable, 0);
      tick();
      check("load_n one clock", sif.load_n, 1);
      check("t_enable in send", sif.t_enable, 1);
      if (send_clks == 0) begin
         while (!(sif.ack0 || sif.ack1) && k < TIMEOUT + 64) begin
            tick();
            k++;
         end
         check("timeout send clocks", k, TIMEOUT);
      end else begin
         repeat (send_clks - 1) tick();
         check("still sending", sif.t_enable, 1);
         sif.char_sent = 1'b1;
         tick();
         sif.char_sent = 1'b0;
      end
      check("ack0", sif.ack0, (id == 1'b0));
      check("ack1", sif.ack1, (id == 1'b1));
      check("tx_err", sif.tx_err, err);
      check("t_enable at done", sif.t_enable, 0);
      check("frame frozen", sif.frame, fr);
      check("busy at done", sif.busy, 1);
      if (drop) begin
         if (id) sif.req1 = 1'b0;
         else    sif.req0 = 1'b0;
      end
      tick();
      check("ack pulse width", sif.ack0 | sif.ack1, 0);
      check("tx_err pulse width", sif.tx_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      sif.req0      = 1'b1;
      sif.data0     = 8'hA5;
      sif.req1      = 1'b0;
      sif.data1     = 8'h00;
      sif.char_sent = 1'b0;
      repeat (3) tick();

      check("rst frame", sif.frame, 10'h3FF);
      check("rst load_n", sif.load_n, 1);
      check("rst t_enable", sif.t_enable, 0);
      check("rst ack0", sif.ack0, 0);
      check("rst ack1", sif.ack1, 0);
      check("rst tx_err", sif.tx_err, 0);
      check("rst busy", sif.busy, 0);
      check("rst grant_id", sif.grant_id, 1);

      reset = 1'b1;
      run_char(1'b0, 10'h34A, 5, 1'b0, 1'b1, w_clks);
      check("first grant latency", w_clks, 1);
      wait_idle();

      sif.data1 = 8'h3C;
      sif.req1  = 1'b1;
      run_char(1'b1, 10'h278, 100, 1'b0, 1'b1, w_clks);
      wait_idle();
      check("frame held after done", sif.frame, 10'h278);
      check("grant_id held", sif.grant_id, 1);

      sif.data0 = 8'h11;
      sif.data1 = 8'h22;
      sif.req0  = 1'b1;
      sif.req1  = 1'b1;
      run_char(1'b0, 10'h222, 3, 1'b0, 1'b0, w_clks);
      run_char(1'b1, 10'h244, 3, 1'b0, 1'b0, w_clks);
      check("ack to next load", w_clks + 1, EXP_GAP);
      run_char(1'b0, 10'h222, 3, 1'b0, 1'b0, w_clks);
      check("ack to next load", w_clks + 1, EXP_GAP);
      run_char(1'b1, 10'h244, 3, 1'b0, 1'b1, w_clks);
      check("ack to next load", w_clks + 1, EXP_GAP);
      sif.req0 = 1'b0;
      wait_idle();

      sif.data0 = 8'h5A;
      sif.req0  = 1'b1;
      run_char(1'b0, 10'h2B4, 0, 1'b1, 1'b1, w_clks);
      wait_idle();

      sif.data1 = 8'h81;
      sif.req1  = 1'b1;
      run_char(1'b1, 10'h302, TIMEOUT, 1'b0, 1'b1, w_clks);
      wait_idle();

      sif.char_sent = 1'b1;
      tick();
      sif.char_sent = 1'b0;
      check("char_sent in idle busy", sif.busy, 0);
      check("char_sent in idle ack", sif.ack0 | sif.ack1, 0);
      tick();
      check("char_sent in idle stays", sif.busy, 0);

      sif.data0 = 8'h00;
      sif.req0  = 1'b1;
      begin
         int k = 0;
         while (sif.load_n !== 1'b0 && k < 64) begin
            tick();
            k++;
         end
      end
      check("abort frame", sif.frame, 10'h200);
      repeat (11) tick();
      check("abort pre t_enable", sif.t_enable, 1);
      reset = 1'b0;
      #1;
      check("abort t_enable", sif.t_enable, 0);
      check("abort busy", sif.busy, 0);
      check("abort load_n", sif.load_n, 1);
      check("abort frame reset", sif.frame, 10'h3FF);
      check("abort grant_id", sif.grant_id, 1);
      sif.req0 = 1'b0;
      repeat (3) begin
         tick();
         check("abort no ack", sif.ack0 | sif.ack1, 0);
      end
      reset = 1'b1;
      tick();
      check("after abort idle", sif.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
